// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath blocks.
//   WIDTH     : datapath operand width (the ripple adder is fixed at 32 bits)
//   CNT_W     : width of the shift-add iteration counter
//   state_t   : multiplier FSM encoding (IDLE -> CALC -> DONE -> IDLE)
//   add_carry : rebuilds the carry-out of a 32-bit add from the operand and
//               sum MSBs, for adders that do not expose a cout port
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  // Value of the counter during the final (32nd) shift-add iteration.
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Carry out of the MSB: both operands set, or exactly one set and the sum
  // bit cleared (a carry propagated into bit 31 and out again).
  function automatic logic add_carry(input logic x_msb,
                                     input logic y_msb,
                                     input logic s_msb);
    add_carry = (x_msb & y_msb) | ((x_msb ^ y_msb) & ~s_msb);
  endfunction

endpackage

// File: rtl/full_adder_32.sv
// -----------------------------------------------------------------------------
// full_adder_32
// 32-bit ripple-carry adder built from a chain of single-bit full adders.
// There is deliberately no carry-out port; users derive it from the MSBs.
// Ports:
//   x, y  in  32  addends
//   cin   in   1  carry into bit 0
//   s     out 32  sum (modulo 2^32)
// -----------------------------------------------------------------------------
module full_adder_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] s
);

  logic [32:0] carry_s;

  assign carry_s[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      assign s[gi]         = x[gi] ^ y[gi] ^ carry_s[gi];
      assign carry_s[gi+1] = (x[gi] & y[gi]) | (carry_s[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  // The final carry is intentionally not exported.
  logic unused_carry_s;
  assign unused_carry_s = carry_s[32];

endmodule

// File: rtl/mul_shift_add_32.sv
// -----------------------------------------------------------------------------
// mul_shift_add_32
// Sequential unsigned 32x32->64 radix-2 shift-add multiplier. One conditional
// add of the multiplicand per clock through a single full_adder_32.
// Parameters:
//   WIDTH      operand width, 32 only
//   ZERO_SKIP  1: a zero operand finishes in one cycle with product 0
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   operands valid
//   in_ready   out  1   operands accepted (high only in IDLE)
//   a          in  32   multiplicand
//   b          in  32   multiplier
//   out_valid  out  1   product valid (high only in DONE)
//   out_ready  in   1   consumer takes product
//   p          out 64   product (0 outside DONE)
//   busy       out  1   high while iterating
// -----------------------------------------------------------------------------
module mul_shift_add_32 #(
  parameter int WIDTH     = 32,
  parameter int ZERO_SKIP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  import alu_pkg::*;

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     mcand_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic [2*WIDTH-1:0]   p_r;

  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 carry_s;
  logic [2*WIDTH-1:0]   acc_next_s;
  logic                 zero_op_s;

  // Multiplicand is added only when the current multiplier LSB is set.
  always_comb begin
    addend_s = {WIDTH{1'b0}};
    if (acc_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
  end

  full_adder_32 u_add (
    .x   (acc_r[2*WIDTH-1:WIDTH]),
    .y   (addend_s),
    .cin (1'b0),
    .s   (sum_s)
  );

  // With a zero addend the derived carry is 0, which gives the bypass case.
  assign carry_s    = add_carry(acc_r[2*WIDTH-1], addend_s[WIDTH-1], sum_s[WIDTH-1]);
  assign acc_next_s = {carry_s, sum_s, acc_r[WIDTH-1:1]};
  assign zero_op_s  = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      mcand_r     <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      p_r         <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid && in_ready_r) begin
            mcand_r    <= a;
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            if ((ZERO_SKIP != 0) && zero_op_s) begin
              acc_r       <= {(2*WIDTH){1'b0}};
              state_r     <= S_DONE;
              out_valid_r <= 1'b1;
              p_r         <= {(2*WIDTH){1'b0}};
            end else begin
              acc_r   <= {{WIDTH{1'b0}}, b};
              state_r <= S_CALC;
              busy_r  <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        S_CALC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            // Final iteration: publish the finished product directly.
            state_r     <= S_DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            p_r         <= acc_next_s;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            p_r         <= {(2*WIDTH){1'b0}};
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= S_DONE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          p_r         <= {(2*WIDTH){1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign p         = p_r;

endmodule

// File: tb/tb_mul_shift_add_32.sv
// -----------------------------------------------------------------------------
// tb_mul_shift_add_32
// Scoreboard bench: the driver pushes a*b for every accepted operand pair and a
// monitor pops/compares whenever the DUT hands out a product. A second instance
// with ZERO_SKIP=0 covers the no-skip zero case.
// -----------------------------------------------------------------------------
module tb_mul_shift_add_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b;
  logic [63:0] p;
  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [63:0] p0;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_accept = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mul_shift_add_32 #(.WIDTH(32), .ZERO_SKIP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  mul_shift_add_32 #(.WIDTH(32), .ZERO_SKIP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready0),
    .p(p0), .busy(busy0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'h0;
    else if (r == 1) return 32'hFFFF_FFFF;
    else return $urandom;
  endfunction

  // Present operands and wait (bounded) for the accepting edge.
  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input bit push);
    int n;
    @(negedge clk);
    a = aa; b = bb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      last_accept = cyc;
      if (push) exp_q.push_back({32'h0, aa} * {32'h0, bb});
      #1 in_valid = 1'b0;
    end
  endtask

  // Count cycles from the accept edge until out_valid; also count busy cycles.
  task automatic wait_out(input string name, input int lat);
    int n, nb;
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end while (!out_valid && n < 100);
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_busy_cycles"}, 64'(nb), 64'(lat - 1));
  endtask

  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", p);
        end else begin
          e = exp_q.pop_front();
          chk("product", p, e);
        end
      end else if (!rst && !out_valid) begin
        chk("p_zero_when_not_valid", p, 64'h0);
      end
    end
  endtask

  initial begin
    int          n;
    int          prev_acc;
    bit          prev_zero;
    logic [31:0] aa, bb;

    rst = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0;
    a = 32'h0; b = 32'h0; out_ready = 1'b1; out_ready0 = 1'b1;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_p", p, 64'h0);
    @(negedge clk) rst = 1'b0;

    // 3 x 5
    send(32'd3, 32'd5, 1'b1);
    chk("t1_in_ready_low", 64'(in_ready), 64'd0);
    wait_out("t1", 33);
    @(negedge clk);
    chk("t1_in_ready_back", 64'(in_ready), 64'd1);

    // all-ones squared exercises the derived carry on every step
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_out("t2", 33);

    // zero skip
    send(32'd0, 32'd7, 1'b1);
    wait_out("t3_skip", 1);

    // zero operand without skip
    @(negedge clk);
    a = 32'd0; b = 32'd7; in_valid0 = 1'b1;
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid0 && n < 100);
    chk("t3_noskip_latency", 64'(n), 64'd33);
    chk("t3_noskip_p", p0, 64'h0);

    // backpressure
    out_ready = 1'b0;
    send(32'h1234_5678, 32'd16, 1'b1);
    wait_out("t4", 33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_p", p, 64'h0000_0001_2345_6780);
      chk("t4_in_ready_low", 64'(in_ready), 64'd0);
      in_valid = i[0];
      a = $urandom; b = $urandom;
    end
    @(posedge clk);
    #2 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_in_ready_back", 64'(in_ready), 64'd1);

    // reset in the middle of a calculation
    send(32'd7, 32'd9, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("t5_after_in_ready", 64'(in_ready), 64'd1);
    chk("t5_after_out_valid", 64'(out_valid), 64'd0);
    send(32'd2, 32'd4, 1'b1);
    wait_out("t5", 33);

    // back-to-back random pairs
    prev_acc = 0; prev_zero = 1'b0;
    for (int i = 0; i < 200; i++) begin
      aa = pick();
      bb = pick();
      send(aa, bb, 1'b1);
      if (i > 0) chk("t6_spacing", 64'(last_accept - prev_acc), prev_zero ? 64'd2 : 64'd34);
      prev_acc  = last_accept;
      prev_zero = (aa == 32'h0) || (bb == 32'h0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
